add_serial_sched: RTL and testbench

Round-robin scheduler that shares one bit-serial adder engine among `NREQ` requesters. It arbitrates pending requests, captures the winner's operands, and sequences the engine through `WIDTH` LSB-first add cycles. It returns the sum with a one-cycle result pulse tagged by requester index. It sits between the operand producers and the serial adder datapath, replacing per-client adders with one time-shared unit.

---
 rtl/add_sched_pkg.sv | 45 ++++
 rtl/serial_add_core.sv | 70 +++++++
 rtl/add_serial_sched.sv | 167 ++++++++++++++++
 tb/tb_add_serial_sched.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_sched_pkg.sv
// rtl/add_sched_pkg.sv - shared types, defaults and round-robin pick for the serial-add scheduler
package add_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ADD  = 2'd2,
        ST_DONE = 2'd3
    } sched_state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREQ  = 4;
    localparam int MAX_NREQ  = 32;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } rr_pick_t;

    // Walks offsets from high to low so the smallest offset from ptr is the last write and wins.
    function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] req_vec,
                                         input int ptr,
                                         input int nreq);
        rr_pick_t   p;
        int         j;
        logic [4:0] j5;
        p.found = 1'b0;
        p.idx   = '0;
        for (int i = MAX_NREQ - 1; i >= 0; i--) begin
            if (i < nreq) begin
                j = ptr + i;
                if (j >= nreq) begin
                    j = j - nreq;
                end
                j5 = 5'(j);
                if (req_vec[j5]) begin
                    p.found = 1'b1;
                    p.idx   = j5;
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/serial_add_core.sv
// rtl/serial_add_core.sv - LSB-first bit-serial adder: operand shifters, carry, bit counter, result shifter
module serial_add_core
    import add_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a_ld,
    input  logic [WIDTH-1:0] b_ld,
    output logic             last,
    output logic [WIDTH-1:0] res_next,
    output logic             carry_next
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // Only WIDTH-1 sum bits are stored; the final bit is folded in combinationally on the last step.
    logic [WIDTH-2:0] res_sr_q, res_sr_d;
    logic             sum_bit;

    always_comb begin
        sum_bit    = a_q[0] ^ b_q[0] ^ carry_q;
        carry_next = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        res_next   = {sum_bit, res_sr_q};
        last       = (cnt_q == CW'(WIDTH - 1));

        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        res_sr_d = res_sr_q;
        if (load) begin
            a_d      = a_ld;
            b_d      = b_ld;
            carry_d  = 1'b0;
            cnt_d    = '0;
            res_sr_d = '0;
        end else if (step) begin
            a_d      = a_q >> 1;
            b_d      = b_q >> 1;
            carry_d  = carry_next;
            cnt_d    = cnt_q + CW'(1);
            res_sr_d = res_next[WIDTH-1:1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            res_sr_q <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            res_sr_q <= res_sr_d;
        end
    end

endmodule

// File: rtl/add_serial_sched.sv
// rtl/add_serial_sched.sv - round-robin scheduler sharing one serial adder among NREQ requesters
// Define ADD_SCHED_COUT_EN to expose the final carry on the cout port.
module add_serial_sched
    import add_sched_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int NREQ  = DEF_NREQ,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic [WIDTH-1:0]      res,
    output logic [IDW-1:0]        res_id,
    output logic                  res_valid
`ifdef ADD_SCHED_COUT_EN
    ,
    output logic                  cout
`endif
);

    sched_state_e          state_q, state_d;
    logic [NREQ-1:0]       gnt_q, gnt_d;
    logic                  busy_q, busy_d;
    logic [WIDTH-1:0]      res_q, res_d;
    logic [IDW-1:0]        res_id_q, res_id_d;
    logic                  res_valid_q, res_valid_d;
    logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]        win_q, win_d;

    logic [MAX_NREQ-1:0]   req_ext;
    rr_pick_t              pick;
    logic [IDW-1:0]        pick_idx;
    logic [4:0]            unused_pick_idx;
    logic [IDW-1:0]        ptr_after_win;

    logic                  core_load;
    logic                  core_step;
    logic                  core_last;
    logic [WIDTH-1:0]      core_res_next;
    logic                  core_carry_next;
    logic [WIDTH-1:0]      a_sel;
    logic [WIDTH-1:0]      b_sel;

`ifdef ADD_SCHED_COUT_EN
    logic                  cout_q, cout_d;
`else
    logic                  unused_carry;
    assign unused_carry = core_carry_next;
`endif

    always_comb begin
        req_ext            = '0;
        req_ext[NREQ-1:0]  = req;
    end

    assign pick            = rr_pick(req_ext, int'(rr_ptr_q), NREQ);
    assign pick_idx        = pick.idx[IDW-1:0];
    assign unused_pick_idx = pick.idx;
    assign ptr_after_win   = (win_q == IDW'(NREQ - 1)) ? '0 : win_q + IDW'(1);

    // Operands are only sampled by the core in LOAD, when win_q already names the winner.
    assign a_sel = a_in[win_q*WIDTH +: WIDTH];
    assign b_sel = b_in[win_q*WIDTH +: WIDTH];

    serial_add_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (core_load),
        .step      (core_step),
        .a_ld      (a_sel),
        .b_ld      (b_sel),
        .last      (core_last),
        .res_next  (core_res_next),
        .carry_next(core_carry_next)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = '0;
        res_valid_d = 1'b0;
        res_d       = res_q;
        res_id_d    = res_id_q;
        rr_ptr_d    = rr_ptr_q;
        win_d       = win_q;
        core_load   = 1'b0;
        core_step   = 1'b0;
`ifdef ADD_SCHED_COUT_EN
        cout_d      = cout_q;
`endif
        case (state_q)
            // DONE re-arbitrates directly so back-to-back results need no IDLE bubble.
            ST_IDLE, ST_DONE: begin
                if (pick.found) begin
                    win_d   = pick_idx;
                    gnt_d   = NREQ'(1) << pick_idx;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                core_load = 1'b1;
                state_d   = ST_ADD;
            end
            ST_ADD: begin
                core_step = 1'b1;
                if (core_last) begin
                    res_d       = core_res_next;
                    res_id_d    = win_q;
                    res_valid_d = 1'b1;
                    rr_ptr_d    = ptr_after_win;
`ifdef ADD_SCHED_COUT_EN
                    cout_d      = core_carry_next;
`endif
                    state_d     = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            res_q       <= '0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
            win_q       <= '0;
`ifdef ADD_SCHED_COUT_EN
            cout_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            res_q       <= res_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
            rr_ptr_q    <= rr_ptr_d;
            win_q       <= win_d;
`ifdef ADD_SCHED_COUT_EN
            cout_q      <= cout_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign res       = res_q;
    assign res_id    = res_id_q;
    assign res_valid = res_valid_q;
`ifdef ADD_SCHED_COUT_EN
    assign cout      = cout_q;
`endif

endmodule

// File: tb/tb_add_serial_sched.sv
// tb/tb_add_serial_sched.sv - directed self-checking bench for add_serial_sched (WIDTH=8, NREQ=4)
module tb_add_serial_sched;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [3:0]  gnt;
    logic        busy;
    logic [7:0]  res;
    logic [1:0]  res_id;
    logic        res_valid;
`ifdef ADD_SCHED_COUT_EN
    logic        cout;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    add_serial_sched #(
        .WIDTH(WIDTH),
        .NREQ (NREQ)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .a_in     (a_in),
        .b_in     (b_in),
        .gnt      (gnt),
        .busy     (busy),
        .res      (res),
        .res_id   (res_id),
        .res_valid(res_valid)
`ifdef ADD_SCHED_COUT_EN
        ,
        .cout     (cout)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic set_ops(input int idx, input logic [7:0] a, input logic [7:0] b);
        a_in[idx*8 +: 8] = a;
        b_in[idx*8 +: 8] = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_grant(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (gnt !== 4'b0000) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
        #1;
        total++;
        if ({gnt, busy, res, res_id, res_valid} !== 16'h0000) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0000", {gnt, busy, res, res_id, res_valid});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({gnt, busy, res_valid} !== 6'b0) begin
            bad++;
            $display("FAIL reset_idle: got %b want 000000", {gnt, busy, res_valid});
        end
    endtask

    task automatic test_single();
        int n;
        set_ops(0, 8'h3C, 8'h05);
        req = 4'b0001;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0001 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_gnt: got gnt=%b busy=%b want 0001 1", gnt, busy);
        end
        req = 4'b0000;
        wait_valid(20, n);
        total++;
        if (n !== 9) begin
            bad++;
            $display("FAIL single_latency: got %0d want 9 cycles after gnt", n);
        end
        total++;
        if (res !== 8'h41 || res_id !== 2'd0 || gnt !== 4'b0000) begin
            bad++;
            $display("FAIL single_result: got res=%h id=%0d gnt=%b want 41 0 0000", res, res_id, gnt);
        end
        @(negedge clk);
        total++;
        if (res_valid !== 1'b0 || res !== 8'h41 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_hold: got v=%b res=%h busy=%b want 0 41 0", res_valid, res, busy);
        end
    endtask

    task automatic test_overflow();
        int n;
        set_ops(1, 8'hFF, 8'h01);
        req = 4'b0010;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0010) begin
            bad++;
            $display("FAIL ovf_gnt: got %b want 0010", gnt);
        end
        req = 4'b0000;
        wait_valid(20, n);
        total++;
        if (n !== 9 || res !== 8'h00 || res_id !== 2'd1) begin
            bad++;
            $display("FAIL ovf_result: got n=%0d res=%h id=%0d want 9 00 1", n, res, res_id);
        end
`ifdef ADD_SCHED_COUT_EN
        total++;
        if (cout !== 1'b1) begin
            bad++;
            $display("FAIL ovf_cout: got %b want 1", cout);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [7:0] sums [4];
        int n;
        int prev_cyc;
        bit ok;
        sums[0] = 8'h11;
        sums[1] = 8'h22;
        sums[2] = 8'h33;
        sums[3] = 8'h44;
        prev_cyc = 0;
        do_reset();
        set_ops(0, 8'h10, 8'h01);
        set_ops(1, 8'h20, 8'h02);
        set_ops(2, 8'h30, 8'h03);
        set_ops(3, 8'h40, 8'h04);
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_grant(15, n);
            total++;
            if (n < 0 || gnt !== (4'b0001 << (g % 4))) begin
                bad++;
                $display("FAIL rr_gnt%0d: got %b (n=%0d) want %b", g, gnt, n, 4'b0001 << (g % 4));
            end
            if (g == 4) req = 4'b0000;
            wait_valid(20, n);
            total++;
            if (n !== 9 || res !== sums[g % 4] || res_id !== 2'(g % 4)) begin
                bad++;
                $display("FAIL rr_res%0d: got n=%0d res=%h id=%0d want 9 %h %0d",
                         g, n, res, res_id, sums[g % 4], g % 4);
            end
            if (g > 0) begin
                total++;
                if (cyc - prev_cyc !== 10) begin
                    bad++;
                    $display("FAIL rr_spacing%0d: got %0d want 10", g, cyc - prev_cyc);
                end
            end
            prev_cyc = cyc;
        end
        wait_idle(30, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL rr_drain: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_fairness();
        int n;
        bit ok;
        do_reset();
        set_ops(2, 8'h01, 8'h02);
        set_ops(3, 8'h05, 8'h06);
        set_ops(0, 8'h0A, 8'h0A);
        req = 4'b0100;
        wait_grant(5, n);
        total++;
        if (gnt !== 4'b0100) begin
            bad++;
            $display("FAIL fair_gnt2: got %b want 0100", gnt);
        end
        req = 4'b1001;
        wait_valid(20, n);
        total++;
        if (res !== 8'h03 || res_id !== 2'd2) begin
            bad++;
            $display("FAIL fair_res2: got res=%h id=%0d want 03 2", res, res_id);
        end
        wait_grant(5, n);
        total++;
        if (gnt !== 4'b1000) begin
            bad++;
            $display("FAIL fair_gnt3: got %b want 1000", gnt);
        end
        wait_valid(20, n);
        total++;
        if (res !== 8'h0B || res_id !== 2'd3) begin
            bad++;
            $display("FAIL fair_res3: got res=%h id=%0d want 0b 3", res, res_id);
        end
        wait_grant(5, n);
        total++;
        if (gnt !== 4'b0001) begin
            bad++;
            $display("FAIL fair_gnt0: got %b want 0001", gnt);
        end
        req = 4'b0000;
        wait_valid(20, n);
        total++;
        if (res !== 8'h14 || res_id !== 2'd0) begin
            bad++;
            $display("FAIL fair_res0: got res=%h id=%0d want 14 0", res, res_id);
        end
        wait_idle(5, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL fair_drain: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_withdraw();
        int n;
        do_reset();
        set_ops(0, 8'h20, 8'h01);
        set_ops(1, 8'h77, 8'h11);
        set_ops(2, 8'h40, 8'h02);
        req = 4'b0111;
        wait_grant(5, n);
        total++;
        if (gnt !== 4'b0001) begin
            bad++;
            $display("FAIL wd_gnt0: got %b want 0001", gnt);
        end
        repeat (2) @(negedge clk);
        req = 4'b0100;
        wait_valid(20, n);
        total++;
        if (res !== 8'h21 || res_id !== 2'd0) begin
            bad++;
            $display("FAIL wd_res0: got res=%h id=%0d want 21 0", res, res_id);
        end
        wait_grant(5, n);
        total++;
        if (gnt !== 4'b0100) begin
            bad++;
            $display("FAIL wd_gnt2: got %b want 0100", gnt);
        end
        req = 4'b0000;
        wait_valid(20, n);
        total++;
        if (res !== 8'h42 || res_id !== 2'd2) begin
            bad++;
            $display("FAIL wd_res2: got res=%h id=%0d want 42 2", res, res_id);
        end
    endtask

    task automatic test_reset_mid_add();
        int n;
        bit seen;
        set_ops(0, 8'h3C, 8'h05);
        req = 4'b0001;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0001) begin
            bad++;
            $display("FAIL rst_gnt: got %b want 0001", gnt);
        end
        req = 4'b0000;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({gnt, busy, res, res_id, res_valid} !== 16'h0000) begin
            bad++;
            $display("FAIL rst_mid_outputs: got %h want 0000", {gnt, busy, res, res_id, res_valid});
        end
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (res_valid !== 1'b0) seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL rst_no_valid: got activity=1 want 0");
        end
        set_ops(1, 8'h12, 8'h34);
        req = 4'b0010;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0010) begin
            bad++;
            $display("FAIL rst_after_gnt: got %b want 0010", gnt);
        end
        req = 4'b0000;
        wait_valid(20, n);
        total++;
        if (n !== 9 || res !== 8'h46 || res_id !== 2'd1) begin
            bad++;
            $display("FAIL rst_after_res: got n=%0d res=%h id=%0d want 9 46 1", n, res, res_id);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_back_to_back();
        test_fairness();
        test_withdraw();
        test_reset_mid_add();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
